// File: rtl/bumpy_move_ctrl.sv
// ---------------------------------------------------------------------------
// bumpy_move_ctrl
// Frame-paced movement controller for the Bumpy player object. It turns
// active-low key presses and the four neighbouring tile types into moves
// that are one tile wide. Each move emits one unit step per video frame.
// The block also handles falling, bouncing off walls, death with a timed
// respawn, a lives counter and game-over.
//
// Optional feature macro: BUMPY_MOVE_INVULN_EN
//   When defined, a respawn starts a grace period of INVULN_FRAMES frames.
//   During that period a DEATH tile below the player ends a move in IDLE
//   instead of DIE.
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle tick per video frame; all state updates happen here
//   up_n/left_n/right_n/down_n  keys, active-low
//   area           neighbour tile types, field [0]=left [1]=up [2]=right [3]=down
//   state          current state code (registered)
//   step_valid     one-cycle step strobe (registered)
//   dx, dy         signed unit step (-1/0/+1), valid with step_valid; dy +1 = down
//   lives          remaining lives (registered)
//   die_pulse      one cycle on DIE entry (registered)
//   respawn_pulse  one cycle on leaving DIE with lives left (registered)
//   game_over      high in OVER (registered)
// ---------------------------------------------------------------------------
module bumpy_move_ctrl #(
    parameter int TILE_PX       = 32,
    parameter int BOUNCE_PX     = 8,
    parameter int DIE_FRAMES    = 60,
    parameter int LIVES         = 3,
    parameter int LIFE_W        = 3,
    parameter int TYPE_W        = 3,
    parameter int INVULN_FRAMES = 120
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                up_n,
    input  logic                left_n,
    input  logic                right_n,
    input  logic                down_n,
    input  logic [4*TYPE_W-1:0] area,
    output logic [3:0]          state,
    output logic                step_valid,
    output logic [1:0]          dx,
    output logic [1:0]          dy,
    output logic [LIFE_W-1:0]   lives,
    output logic                die_pulse,
    output logic                respawn_pulse,
    output logic                game_over
);

    localparam int CNT_MAX = (TILE_PX > DIE_FRAMES) ? TILE_PX : DIE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_TILE  = CNT_W'(TILE_PX - 1);
    localparam logic [CNT_W-1:0]  CNT_BNC   = CNT_W'(BOUNCE_PX - 1);
    localparam logic [CNT_W-1:0]  CNT_DIE   = CNT_W'(DIE_FRAMES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0] LIFE_ONE  = LIFE_W'(32'd1);

    // Tile type codes; any code above WALL behaves as REGU
    localparam logic [TYPE_W-1:0] T_FREE  = TYPE_W'(32'd0);
    localparam logic [TYPE_W-1:0] T_REGU  = TYPE_W'(32'd1);
    localparam logic [TYPE_W-1:0] T_DEATH = TYPE_W'(32'd3);
    localparam logic [TYPE_W-1:0] T_WALL  = TYPE_W'(32'd4);

    // Step direction codes
    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_IDLE     = 4'd1,
        S_MOVE_L   = 4'd2,
        S_MOVE_R   = 4'd3,
        S_MOVE_U   = 4'd4,
        S_FALL     = 4'd5,
        S_BNC_OUT  = 4'd6,
        S_BNC_BACK = 4'd7,
        S_DIE      = 4'd8,
        S_OVER     = 4'd9
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_step_valid;
    logic [1:0]         r_step_dir;
    logic [1:0]         r_bdir;
    logic [LIFE_W-1:0]  r_lives;
    logic               r_die_pulse;
    logic               r_resp_pulse;
    logic               r_game_over;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_step_nxt;
    logic [1:0]         w_dir_nxt;
    logic [1:0]         w_bdir_nxt;
    logic [LIFE_W-1:0]  w_lives_nxt;
    logic               w_die_nxt;
    logic               w_resp_nxt;
    logic               w_death_eff;

    logic [TYPE_W-1:0]  w_area_l;
    logic [TYPE_W-1:0]  w_area_u;
    logic [TYPE_W-1:0]  w_area_r;
    logic [TYPE_W-1:0]  w_area_d;
    logic               w_key_u;
    logic               w_key_l;
    logic               w_key_r;
    logic               w_key_d;

    assign w_area_l = area[0*TYPE_W +: TYPE_W];
    assign w_area_u = area[1*TYPE_W +: TYPE_W];
    assign w_area_r = area[2*TYPE_W +: TYPE_W];
    assign w_area_d = area[3*TYPE_W +: TYPE_W];

    assign w_key_u = ~up_n;
    assign w_key_l = ~left_n;
    assign w_key_r = ~right_n;
    assign w_key_d = ~down_n;

    function automatic logic f_is_regu(input logic [TYPE_W-1:0] code);
        return (code == T_REGU) || (code > T_WALL);
    endfunction

    function automatic logic [1:0] f_opp_dir(input logic [1:0] d);
        logic [1:0] o;
        case (d)
            DIR_L:   o = DIR_R;
            DIR_R:   o = DIR_L;
            DIR_U:   o = DIR_D;
            DIR_D:   o = DIR_U;
            default: o = d;
        endcase
        return o;
    endfunction

    function automatic logic [1:0] f_move_dir(input state_t s);
        logic [1:0] d;
        case (s)
            S_MOVE_L: d = DIR_L;
            S_MOVE_R: d = DIR_R;
            S_MOVE_U: d = DIR_U;
            S_FALL:   d = DIR_D;
            default:  d = DIR_D;
        endcase
        return d;
    endfunction

`ifdef BUMPY_MOVE_INVULN_EN
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    logic [INV_W-1:0] r_invuln;

    // Grace counter: reloaded by a respawn, then counts frames down to zero
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_invuln <= '0;
        end else if (startOfFrame) begin
            if (w_resp_nxt) begin
                r_invuln <= INV_W'(INVULN_FRAMES);
            end else if (r_invuln != '0) begin
                r_invuln <= r_invuln - INV_W'(32'd1);
            end else begin
                r_invuln <= r_invuln;
            end
        end else begin
            r_invuln <= r_invuln;
        end
    end

    assign w_death_eff = (w_area_d == T_DEATH) && (r_invuln == '0);
`else
    logic [31:0] w_unused_invuln;

    assign w_unused_invuln = 32'(INVULN_FRAMES);
    assign w_death_eff     = (w_area_d == T_DEATH);
`endif

    // Next-state, counter, lives and strobe decode; only acts on frame ticks
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        w_dir_nxt   = r_step_dir;
        w_bdir_nxt  = r_bdir;
        w_lives_nxt = r_lives;
        w_die_nxt   = 1'b0;
        w_resp_nxt  = 1'b0;
        if (startOfFrame) begin
            case (r_state)
                S_RESET: begin
                    if (w_key_u || w_key_l || w_key_r || w_key_d) begin
                        w_state_nxt = S_FALL;
                        w_cnt_nxt   = CNT_TILE;
                    end else begin
                        w_state_nxt = S_RESET;
                    end
                end
                S_IDLE: begin
                    // Priority up > left > right; down alone does nothing
                    if (w_key_u) begin
                        if ((w_area_u == T_WALL) || f_is_regu(w_area_u)) begin
                            w_state_nxt = S_BNC_OUT;
                            w_bdir_nxt  = DIR_U;
                            w_cnt_nxt   = CNT_BNC;
                        end else begin
                            w_state_nxt = S_MOVE_U;
                            w_cnt_nxt   = CNT_TILE;
                        end
                    end else if (w_key_l) begin
                        if (w_area_l == T_WALL) begin
                            w_state_nxt = S_BNC_OUT;
                            w_bdir_nxt  = DIR_L;
                            w_cnt_nxt   = CNT_BNC;
                        end else begin
                            w_state_nxt = S_MOVE_L;
                            w_cnt_nxt   = CNT_TILE;
                        end
                    end else if (w_key_r) begin
                        if (w_area_r == T_WALL) begin
                            w_state_nxt = S_BNC_OUT;
                            w_bdir_nxt  = DIR_R;
                            w_cnt_nxt   = CNT_BNC;
                        end else begin
                            w_state_nxt = S_MOVE_R;
                            w_cnt_nxt   = CNT_TILE;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_MOVE_L, S_MOVE_R, S_MOVE_U, S_FALL: begin
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = f_move_dir(r_state);
                    if (r_cnt == '0) begin
                        // Last step of the tile: the tile below decides what follows
                        if (w_area_d == T_FREE) begin
                            w_state_nxt = S_FALL;
                            w_cnt_nxt   = CNT_TILE;
                        end else if (w_death_eff) begin
                            w_state_nxt = S_DIE;
                            w_cnt_nxt   = CNT_DIE;
                            w_die_nxt   = 1'b1;
                            w_lives_nxt = (r_lives != '0) ? (r_lives - LIFE_ONE) : '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                S_BNC_OUT: begin
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = r_bdir;
                    if (r_cnt == '0) begin
                        w_state_nxt = S_BNC_BACK;
                        w_cnt_nxt   = CNT_BNC;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                S_BNC_BACK: begin
                    // Same number of steps back as out, so the net move is zero
                    w_step_nxt = 1'b1;
                    w_dir_nxt  = f_opp_dir(r_bdir);
                    if (r_cnt == '0) begin
                        if (w_area_d == T_FREE) begin
                            w_state_nxt = S_FALL;
                            w_cnt_nxt   = CNT_TILE;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                S_DIE: begin
                    // Lives were already decremented on entry
                    if (r_cnt == '0) begin
                        if (r_lives != '0) begin
                            w_state_nxt = S_IDLE;
                            w_resp_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_OVER;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                    end
                end
                S_OVER: begin
                    w_state_nxt = S_OVER;
                end
                default: begin
                    w_state_nxt = S_RESET;
                    w_cnt_nxt   = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_step_valid <= 1'b0;
            r_step_dir   <= DIR_D;
            r_bdir       <= DIR_U;
            r_lives      <= LIFE_INIT;
            r_die_pulse  <= 1'b0;
            r_resp_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step_valid <= w_step_nxt;
            r_step_dir   <= w_dir_nxt;
            r_bdir       <= w_bdir_nxt;
            r_lives      <= w_lives_nxt;
            r_die_pulse  <= w_die_nxt;
            r_resp_pulse <= w_resp_nxt;
            r_game_over  <= (w_state_nxt == S_OVER);
        end
    end

    // Unit-step decode from the direction latched with the step strobe
    always_comb begin
        dx = 2'b00;
        dy = 2'b00;
        if (r_step_valid) begin
            case (r_step_dir)
                DIR_L:   dx = 2'b11;
                DIR_R:   dx = 2'b01;
                DIR_U:   dy = 2'b11;
                DIR_D:   dy = 2'b01;
                default: dx = 2'b00;
            endcase
        end else begin
            dx = 2'b00;
            dy = 2'b00;
        end
    end

    assign state         = r_state;
    assign step_valid    = r_step_valid;
    assign lives         = r_lives;
    assign die_pulse     = r_die_pulse;
    assign respawn_pulse = r_resp_pulse;
    assign game_over     = r_game_over;

endmodule

// File: tb/tb_bumpy_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bumpy_move_ctrl
// Self-checking bench for bumpy_move_ctrl with TILE_PX=4, BOUNCE_PX=2,
// DIE_FRAMES=3, LIVES=2. A frame tick is issued every 4 clocks. Every tick
// that must produce a step pushes the expected {dx,dy} into a scoreboard
// queue. A monitor pops and compares the queue on every step strobe.
// ---------------------------------------------------------------------------
module tb_bumpy_move_ctrl;

    localparam int TYPE_W = 3;
    localparam int LIFE_W = 3;

    localparam logic [2:0] FREE  = 3'd0;
    localparam logic [2:0] REGU  = 3'd1;
    localparam logic [2:0] GATE  = 3'd2;
    localparam logic [2:0] DEATH = 3'd3;
    localparam logic [2:0] WALL  = 3'd4;

    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] M1 = 2'b11;
    localparam logic [1:0] Z0 = 2'b00;

    logic                clk = 1'b0;
    logic                resetN;
    logic                startOfFrame;
    logic                up_n, left_n, right_n, down_n;
    logic [4*TYPE_W-1:0] area;
    logic [3:0]          state;
    logic                step_valid;
    logic [1:0]          dx, dy;
    logic [LIFE_W-1:0]   lives;
    logic                die_pulse, respawn_pulse, game_over;

    int n_vec = 0;
    int n_err = 0;
    int die_cnt = 0;
    int resp_cnt = 0;
    int net_dx = 0;
    int net_dy = 0;
    logic [3:0] sb_q[$];

    bumpy_move_ctrl #(
        .TILE_PX(4), .BOUNCE_PX(2), .DIE_FRAMES(3), .LIVES(2),
        .LIFE_W(LIFE_W), .TYPE_W(TYPE_W), .INVULN_FRAMES(120)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .up_n(up_n), .left_n(left_n), .right_n(right_n), .down_n(down_n),
        .area(area), .state(state), .step_valid(step_valid),
        .dx(dx), .dy(dy), .lives(lives), .die_pulse(die_pulse),
        .respawn_pulse(respawn_pulse), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_area(input logic [2:0] l, input logic [2:0] u,
                            input logic [2:0] r, input logic [2:0] d);
        area = {d, r, u, l};
    endtask

    // One frame tick; optionally expect a step with the given direction
    task automatic tick(input bit exp_step, input logic [1:0] edx, input logic [1:0] edy);
        @(negedge clk);
        startOfFrame = 1'b1;
        if (exp_step) sb_q.push_back({edx, edy});
        @(negedge clk);
        startOfFrame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic steps(input int n, input logic [1:0] edx, input logic [1:0] edy);
        for (int i = 0; i < n; i++) tick(1'b1, edx, edy);
    endtask

    // Press one set of keys for exactly one tick (no step on the entry tick)
    task automatic press(input logic u, input logic l, input logic r, input logic d);
        up_n = ~u; left_n = ~l; right_n = ~r; down_n = ~d;
        tick(1'b0, Z0, Z0);
        up_n = 1'b1; left_n = 1'b1; right_n = 1'b1; down_n = 1'b1;
    endtask

    // Scoreboard monitor: every step strobe must match the oldest expectation
    always @(negedge clk) begin
        if (step_valid) begin
            net_dx = net_dx + int'($signed(dx));
            net_dy = net_dy + int'($signed(dy));
            if (sb_q.size() == 0) begin
                check_val("step_unexpected", {28'd0, dx, dy}, 32'hFFFF_FFFF);
            end else begin
                check_val("step_dxdy", {28'd0, dx, dy}, {28'd0, sb_q.pop_front()});
            end
        end
        if (die_pulse) die_cnt++;
        if (respawn_pulse) resp_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0;
        up_n = 1'b1; left_n = 1'b1; right_n = 1'b1; down_n = 1'b1;
        set_area(REGU, REGU, REGU, REGU);
        repeat (3) @(negedge clk);
        check_val("rst_state", state, 4'd0);
        check_val("rst_lives", lives, 3'd2);
        check_val("rst_strobes", {step_valid, die_pulse, respawn_pulse, game_over}, 4'b0000);
        resetN = 1'b1;
        tick(1'b0, Z0, Z0);
        check_val("reset_no_key", state, 4'd0);

        // 1: any key leaves RESET into FALL; FREE below re-arms the fall
        set_area(REGU, REGU, REGU, FREE);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("t1_fall", state, 4'd5);
        steps(4, Z0, P1);
        check_val("t1_rearm", state, 4'd5);
        set_area(REGU, REGU, REGU, REGU);
        steps(3, Z0, P1);
        check_val("t1_mid", state, 4'd5);
        steps(1, Z0, P1);
        check_val("t1_idle", state, 4'd1);
        check_val("t1_sb", sb_q.size(), 0);

        // down alone is ignored in IDLE
        press(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("down_ignored", state, 4'd1);

        // 2: right into a GATE tile
        set_area(REGU, REGU, GATE, REGU);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t2_move_r", state, 4'd3);
        steps(4, P1, Z0);
        check_val("t2_idle", state, 4'd1);

        // 3: up into a WALL bounces with zero net displacement
        set_area(REGU, WALL, REGU, REGU);
        net_dx = 0; net_dy = 0;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t3_bnc_out", state, 4'd6);
        steps(2, Z0, M1);
        check_val("t3_bnc_back", state, 4'd7);
        steps(2, Z0, P1);
        check_val("t3_idle", state, 4'd1);
        check_val("t3_net_dy", net_dy, 0);

        // left into a WALL bounces left then right
        set_area(WALL, REGU, REGU, REGU);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("bnc_l", state, 4'd6);
        steps(2, M1, Z0);
        steps(2, P1, Z0);
        check_val("bnc_l_idle", state, 4'd1);
        check_val("bnc_l_net", net_dx, 0);
        check_val("t3_sb", sb_q.size(), 0);

        // 4: MOVE_L ending on DEATH, then respawn after 3 ticks
        set_area(FREE, REGU, REGU, DEATH);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("t4_move_l", state, 4'd2);
        steps(4, M1, Z0);
        check_val("t4_die", state, 4'd8);
        check_val("t4_lives1", lives, 3'd1);
        check_val("t4_die_cnt", die_cnt, 1);
        tick(1'b0, Z0, Z0);
        tick(1'b0, Z0, Z0);
        check_val("t4_still_die", state, 4'd8);
        tick(1'b0, Z0, Z0);
        check_val("t4_respawn", state, 4'd1);
        check_val("t4_resp_cnt", resp_cnt, 1);
        check_val("t4_lives_kept", lives, 3'd1);

        // 6/4: second death right after respawn
        press(1'b0, 1'b1, 1'b0, 1'b0);
        steps(4, M1, Z0);
`ifdef BUMPY_MOVE_INVULN_EN
        check_val("t6_invuln_idle", state, 4'd1);
        check_val("t6_invuln_lives", lives, 3'd1);
        check_val("t6_invuln_nodie", die_cnt, 1);
        repeat (120) tick(1'b0, Z0, Z0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        steps(4, M1, Z0);
`endif
        check_val("t6_die", state, 4'd8);
        check_val("t4_lives0", lives, 3'd0);
        check_val("t4_die_cnt2", die_cnt, 2);
        repeat (3) tick(1'b0, Z0, Z0);
        check_val("t4_over", state, 4'd9);
        check_val("t4_game_over", game_over, 1'b1);
        check_val("t4_no_resp", resp_cnt, 1);
        press(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("t4_over_keys", state, 4'd9);
        check_val("t4_over_lives", lives, 3'd0);

        // 5: reset, up+left together picks MOVE_U, reset mid-MOVE_R
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t5_rst_go", game_over, 1'b0);
        resetN = 1'b1;
        set_area(REGU, FREE, GATE, REGU);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        steps(4, Z0, P1);
        check_val("t5_idle", state, 4'd1);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("t5_prio_up", state, 4'd4);
        steps(4, Z0, M1);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t5_move_r", state, 4'd3);
        steps(2, P1, Z0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_val("t5_abort_state", state, 4'd0);
        check_val("t5_abort_lives", lives, 3'd2);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        tick(1'b0, Z0, Z0);
        tick(1'b0, Z0, Z0);
        check_val("t5_after_rst", state, 4'd0);
        check_val("t5_sb", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bumpy_move_ctrl.md
Name: bumpy_move_ctrl

Overview:
Parametrised, frame-paced successor to the Bumpy player FSM. It turns key presses and the four neighbouring tile types into tile-granular moves. Each move spans a fixed number of frames and emits per-frame unit steps. The block also handles falling, bouncing off walls and death. It adds a lives counter, a timed death/respawn sequence and game-over. It sits between the key debouncers/tile lookup and the Bumpy object position register.

Parameters:
TILE_PX, 32, frames (one pixel step per frame) per tile move; ≥2
BOUNCE_PX, 8, frames out and frames back for a bounce; 1 ≤ BOUNCE_PX < TILE_PX
DIE_FRAMES, 60, frames held in DIE
LIVES, 3, initial lives; 1 ≤ LIVES < 2^LIFE_W
LIFE_W, 3, lives counter width
TYPE_W, 3, tile-type code width
INVULN_FRAMES, 120, post-respawn grace frames (optional feature only)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle tick per video frame
up_n, left_n, right_n, down_n  in  1 each  keys, active-low
area  in  4xTYPE_W  [0]=left [1]=up [2]=right [3]=down neighbour tile type
state  out  4  current state code
step_valid  out  1  one-cycle step strobe
dx, dy  out  2 each  signed step (-1/0/+1), valid with step_valid; dy +1 = down
lives  out  LIFE_W  remaining lives
die_pulse  out  1  one cycle on DIE entry
respawn_pulse  out  1  one cycle on leaving DIE with lives>0
game_over  out  1  high in OVER

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk. All outputs are registered except dx/dy, which decode from state. Reset values: state=RESET(0), lives=LIVES, frame counter=0, all strobes 0, game_over=0.
- Tile codes: FREE=0, REGU=1, GATE=2, DEATH=3, WALL=4; other codes behave as REGU.
- State codes: RESET=0, IDLE=1, MOVE_L=2, MOVE_R=3, MOVE_U=4, FALL=5, BNC_OUT=6, BNC_BACK=7, DIE=8, OVER=9.
- State transitions and counter updates occur only on cycles with startOfFrame=1. Inputs are sampled on that cycle only.
- RESET -> FALL on any key asserted.
- IDLE key priority: up > left > right > down; down alone is ignored.
  - up: area[1] WALL or REGU -> BNC_OUT (dir up); otherwise MOVE_U.
  - left/right: side tile WALL -> BNC_OUT (that dir); otherwise MOVE_L/MOVE_R. FREE is allowed.
- Move states (MOVE_*, FALL):
  - Counter loads TILE_PX-1 on entry.
  - Each tick: step_valid=1 with dx/dy; MOVE_L -> (-1,0), MOVE_R -> (+1,0), MOVE_U -> (0,-1), FALL -> (0,+1).
  - When counter==0 on a tick, the last step is emitted and the block evaluates area[3]: FREE -> FALL (re-armed), DEATH -> DIE, else IDLE.
- Bounce: BNC_OUT emits BOUNCE_PX steps in the latched direction. BNC_BACK then emits BOUNCE_PX steps in the opposite direction. Then IDLE, or FALL if area[3]==FREE. Net displacement is 0.
- DIE:
  - On entry: lives decrements (saturating at 0), die_pulse=1, no steps.
  - After DIE_FRAMES ticks: lives>0 -> IDLE with respawn_pulse=1; lives==0 -> OVER.
  - The position-register owner restores the start position on respawn_pulse.
- OVER: absorbing state; game_over=1; only reset exits.
- Keys held during a move are ignored; a key held at move end is acted on at the next IDLE tick (auto-repeat).
- Reset mid-move aborts immediately; no partial-step strobe follows.
- Counter width: $clog2(max(TILE_PX, DIE_FRAMES)+1).

Optional Feature:
BUMPY_MOVE_INVULN_EN.
- Defined: respawn loads an invulnerability counter with INVULN_FRAMES, decremented per tick. While it is nonzero, DEATH in area[3] is treated as REGU, so the move ends in IDLE rather than DIE.
- Undefined: no counter; DEATH always leads to DIE.

Test Plan:
TILE_PX=4, BOUNCE_PX=2, DIE_FRAMES=3, LIVES=2. Tick every 4 clocks.
1. Reset, then left_n=0 for 1 tick -> FALL; area[3]=REGU -> exactly 4 step_valid with dy=+1, then state=IDLE.
2. IDLE, right_n=0, area[2]=GATE, area[3]=REGU -> state=3; 4 steps dx=+1; IDLE after tick 4.
3. IDLE, up_n=0, area[1]=WALL -> 2 steps dy=-1, then 2 steps dy=+1; IDLE; net dy=0.
4. MOVE_L ending with area[3]=DEATH -> die_pulse once, lives 2->1; 3 ticks later respawn_pulse, IDLE. Repeat -> lives=0, OVER, game_over=1; keys are ignored.
5. up_n=0 and left_n=0 on the same tick -> MOVE_U chosen. resetN=0 mid-MOVE_R -> state=0, lives=2, no further strobes.
6. BUMPY_MOVE_INVULN_EN defined: death within INVULN_FRAMES after respawn -> IDLE, lives unchanged. Undefined: the same stimulus gives DIE.
